adc_servo_ctrl: RTL and testbench

Consumes the ADC sample stream and drives one hobby-servo control line.
- Selects a single ADC channel and averages 2^AVG_LOG2 samples.
- Maps the average to a 1–2 ms pulse within a fixed 20 ms frame.
- Sits directly downstream of the ADC/AVR sample interface, in parallel with the LED-brightness capture stage, and replaces the LED PWM consumer for servo builds.

---
 rtl/servo_pkg.sv | 26 ++
 rtl/adc_servo_ctrl_if.sv | 24 ++
 rtl/servo_pulse_gen.sv | 45 ++++
 rtl/adc_servo_ctrl.sv | 113 +++++++++++
 tb/tb_adc_servo_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// Shared constants and types for the ADC-driven servo controller.
// Frame/pulse defaults correspond to a 50 MHz clock: 20 ms frame, 1-2 ms pulse.
package servo_pkg;

    localparam int CTR_W   = 20;
    localparam int WIDTH_W = 17;
    localparam int POS_W   = 10;

    localparam int FRAME_CYCLES_DEF = 1000000;
    localparam int MIN_PULSE_DEF    = 50000;
    localparam int PULSE_STEP_DEF   = 49;
    localparam int SLEW_MAX_DEF     = 16;

    localparam int CENTER_POS = 512;

    typedef logic [POS_W-1:0] position_t;

    // Pulse width in clk cycles for a given position (fits 17 bits for any 10-bit position
    // with the default constants).
    function automatic logic [WIDTH_W-1:0] pulse_width(input position_t pos,
                                                       input int min_pulse,
                                                       input int step);
        return WIDTH_W'(min_pulse + int'(pos) * step);
    endfunction

endpackage

// File: rtl/adc_servo_ctrl_if.sv
// ADC sample bus between the ADC/AVR sampler (master) and a sample consumer (slave).
// Handshake: new_sample is a one-cycle strobe qualifying sample and sample_channel;
// there is no ready/backpressure, the consumer must take or drop the sample that cycle.
// channel is the consumer's constant channel request back to the sampler.
interface adc_servo_ctrl_if;
    logic [3:0] channel;
    logic       new_sample;
    logic [9:0] sample;
    logic [3:0] sample_channel;

    modport master (
        input  channel,
        output new_sample,
        output sample,
        output sample_channel
    );

    modport slave (
        output channel,
        input  new_sample,
        input  sample,
        input  sample_channel
    );
endinterface

// File: rtl/servo_pulse_gen.sv
// Servo frame timing: free-running frame counter, registered pulse compare and the
// width register, which only changes on the load strobe at the frame's last cycle.
module servo_pulse_gen
    import servo_pkg::*;
#(
    parameter int                 FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter logic [WIDTH_W-1:0] RESET_WIDTH  = WIDTH_W'(MIN_PULSE_DEF + CENTER_POS * PULSE_STEP_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH_W-1:0] load_width,
    output logic               servo,
    output logic               frame_start,
    output logic               frame_last
);

    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(FRAME_CYCLES - 1);

    logic [CTR_W-1:0]   ctr;
    logic [WIDTH_W-1:0] width;

    assign frame_start = (ctr == '0);
    assign frame_last  = (ctr == CTR_LAST);

    // Frame counter: 0 .. FRAME_CYCLES-1, then wrap.
    always_ff @(posedge clk) begin
        if (rst)             ctr <= '0;
        else if (frame_last) ctr <= '0;
        else                 ctr <= ctr + 1'b1;
    end

    // Width register: loaded only at the frame boundary so a pulse is never cut short.
    always_ff @(posedge clk) begin
        if (rst)       width <= RESET_WIDTH;
        else if (load) width <= load_width;
    end

    // Registered compare: high for exactly width cycles, starting the cycle after ctr==0.
    always_ff @(posedge clk) begin
        if (rst) servo <= 1'b0;
        else     servo <= (ctr < {{(CTR_W-WIDTH_W){1'b0}}, width});
    end

endmodule

// File: rtl/adc_servo_ctrl.sv
// ADC sample -> hobby servo controller. Filters one ADC channel, averages
// 2^AVG_LOG2 samples, and loads the average as the servo position at frame boundaries.
// Optional build macro ADC_SERVO_SLEW_LIMIT_EN: limits the position change per frame
// to SLEW_MAX and keeps the pending target alive until it is reached.
module adc_servo_ctrl
    import servo_pkg::*;
#(
    parameter logic [3:0] CHANNEL      = 4'd0,
    parameter int         AVG_LOG2     = 2,
    parameter int         FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int         MIN_PULSE    = MIN_PULSE_DEF,
    parameter int         PULSE_STEP   = PULSE_STEP_DEF,
    parameter int         SLEW_MAX     = SLEW_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    adc_servo_ctrl_if.slave        adc,
    output logic                   servo,
    output position_t              position,
    output logic                   frame_start
);

    localparam int ACC_W = POS_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [WIDTH_W-1:0] CENTER_WIDTH =
        WIDTH_W'(MIN_PULSE + CENTER_POS * PULSE_STEP);

    logic               accept;
    logic               avg_done;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_sum;
    logic [CNT_W-1:0]   cnt;
    position_t          avg;
    position_t          pending;
    logic               pending_valid;
    position_t          target;
    logic               frame_last;
    logic               do_load;
    logic [WIDTH_W-1:0] load_width;

    assign adc.channel = CHANNEL;

    assign accept   = adc.new_sample && (adc.sample_channel == CHANNEL);
    assign acc_sum  = acc + ACC_W'(adc.sample);
    assign avg_done = accept && (cnt == CNT_LAST);
    assign avg      = POS_W'(acc_sum >> AVG_LOG2);

    // Averager: accumulate accepted samples, clear after the last one of the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (avg_done) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc_sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Next position from the pending average, optionally moved by at most SLEW_MAX.
    always_comb begin
        target = pending;
`ifdef ADC_SERVO_SLEW_LIMIT_EN
        if ((pending > position) && ((pending - position) > POS_W'(SLEW_MAX)))
            target = position + POS_W'(SLEW_MAX);
        else if ((pending < position) && ((position - pending) > POS_W'(SLEW_MAX)))
            target = position - POS_W'(SLEW_MAX);
`endif
    end

    assign do_load    = frame_last && pending_valid;
    assign load_width = pulse_width(target, MIN_PULSE, PULSE_STEP);

    // Pending register: a new average always wins over the boundary consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending       <= '0;
            pending_valid <= 1'b0;
        end else begin
            if (avg_done)
                pending <= avg;
            if (avg_done)
                pending_valid <= 1'b1;
            else if (do_load && (target == pending))
                pending_valid <= 1'b0;
        end
    end

    // Emitted position: updated only at the frame boundary, together with the width.
    always_ff @(posedge clk) begin
        if (rst)          position <= POS_W'(CENTER_POS);
        else if (do_load) position <= target;
    end

    servo_pulse_gen #(
        .FRAME_CYCLES (FRAME_CYCLES),
        .RESET_WIDTH  (CENTER_WIDTH)
    ) u_pulse_gen (
        .clk         (clk),
        .rst         (rst),
        .load        (do_load),
        .load_width  (load_width),
        .servo       (servo),
        .frame_start (frame_start),
        .frame_last  (frame_last)
    );

endmodule

// File: tb/tb_adc_servo_ctrl.sv
// Bench for adc_servo_ctrl with a shortened frame so many frames fit in a short run.
// Reference model: per-cycle frame position, a window queue of accepted samples
// averaged by division, and expected pulse widths queued per frame.
module tb_adc_servo_ctrl;

    localparam int CH       = 0;
    localparam int AVG_LOG2 = 2;
    localparam int N_AVG    = 1 << AVG_LOG2;
    localparam int FC       = 1200;
    localparam int MP       = 50;
    localparam int PS       = 1;
    localparam int SM       = 16;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       servo;
    logic       frame_start;
    logic [9:0] position;

    always #5 clk = ~clk;

    adc_servo_ctrl_if adc_bus();

    adc_servo_ctrl #(
        .CHANNEL      (4'(CH)),
        .AVG_LOG2     (AVG_LOG2),
        .FRAME_CYCLES (FC),
        .MIN_PULSE    (MP),
        .PULSE_STEP   (PS),
        .SLEW_MAX     (SM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .adc         (adc_bus),
        .servo       (servo),
        .position    (position),
        .frame_start (frame_start)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_ctr    = 0;
    int m_pend   = 0;
    bit m_pend_v = 0;
    int m_pos    = 512;
    bit rst_hit  = 0;
    int win[$];

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_ctr    = 0;
                m_pend   = 0;
                m_pend_v = 0;
                m_pos    = 512;
                win.delete();
                rst_hit  = 1;
            end else begin
                if (m_ctr == FC - 1 && m_pend_v) begin
                    int tgt;
                    tgt = m_pend;
`ifdef ADC_SERVO_SLEW_LIMIT_EN
                    if (m_pend - m_pos > SM) tgt = m_pos + SM;
                    if (m_pos - m_pend > SM) tgt = m_pos - SM;
`endif
                    m_pos = tgt;
                    if (tgt == m_pend) m_pend_v = 0;
                end
                if (adc_bus.new_sample && adc_bus.sample_channel == 4'(CH)) begin
                    win.push_back(int'(adc_bus.sample));
                    if (win.size() == N_AVG) begin
                        int s;
                        s = 0;
                        foreach (win[i]) s += win[i];
                        m_pend   = s / N_AVG;
                        m_pend_v = 1;
                        win.delete();
                    end
                end
                m_ctr = (m_ctr + 1) % FC;
            end
        end
    end

    // ---------------- monitor (negedge sampling) ----------------
    bit in_prog = 0;
    int hi_cnt  = 0;
    int per_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_hit) begin
                check("servo_after_rst", 32'(servo), 32'd0);
                rst_hit = 0;
            end
            if (rst) begin
                in_prog = 0;
                exp_q.delete();
            end else begin
                check("frame_start", 32'(frame_start), 32'(m_ctr == 0));
                if (frame_start) begin
                    if (in_prog) begin
                        check("period", 32'(per_cnt), 32'(FC));
                        check("pulse_width", 32'(hi_cnt), exp_q.pop_front());
                    end
                    check("position", 32'(position), 32'(m_pos));
                    exp_q.push_back(32'(MP + m_pos * PS));
                    in_prog = 1;
                    hi_cnt  = int'(servo);
                    per_cnt = 1;
                end else begin
                    hi_cnt  += int'(servo);
                    per_cnt++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int ch, input int val);
        @(posedge clk);
        #1;
        adc_bus.new_sample     = 1'b1;
        adc_bus.sample         = 10'(val);
        adc_bus.sample_channel = 4'(ch);
        @(posedge clk);
        #1;
        adc_bus.new_sample     = 1'b0;
    endtask

    task automatic send4(input int ch, input int val);
        for (int i = 0; i < 4; i++) send(ch, val);
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < n; i++) begin
            bit got;
            got = 0;
            for (int k = 0; k < 2 * FC && !got; k++) begin
                @(negedge clk);
                if (frame_start && !rst) got = 1;
            end
            if (!got) check("frame_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(150000 * 10);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        adc_bus.new_sample     = 1'b0;
        adc_bus.sample         = '0;
        adc_bus.sample_channel = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state: centre position, constant channel request, two full centre frames.
        @(negedge clk);
        check("reset_position", 32'(position), 32'd512);
        check("channel", 32'(adc_bus.channel), 32'(CH));
        wait_frames(3);

`ifdef ADC_SERVO_SLEW_LIMIT_EN
        // Slewed step toward full scale.
        wait_frames(1);
        send4(CH, 1023);
        wait_frames(1);
        check("slew_step1", 32'(position), 32'd528);
        wait_frames(1);
        check("slew_step2", 32'(position), 32'd544);
        wait_frames(1);
`else
        // Averaging 100..400 -> 250.
        wait_frames(1);
        send(CH, 100); send(CH, 200); send(CH, 300); send(CH, 400);
        wait_frames(1);
        check("avg_position", 32'(position), 32'd250);
        wait_frames(1);

        // Other channel ignored.
        send4(3, 1023);
        wait_frames(2);
        check("chan_filter", 32'(position), 32'd250);

        // Full scale, then zero.
        send4(CH, 1023);
        wait_frames(1);
        check("full_scale", 32'(position), 32'd1023);
        wait_frames(1);
        send4(CH, 0);
        wait_frames(1);
        check("zero_scale", 32'(position), 32'd0);
        wait_frames(1);

        // Fourth sample in the frame's last cycle: old value this frame, new value next.
        send(CH, 800); send(CH, 800); send(CH, 800);
        begin
            int k;
            k = 0;
            do begin
                @(posedge clk);
                #1;
                k++;
            end while (m_ctr != FC - 1 && k < 2 * FC);
            if (m_ctr != FC - 1) check("race_timeout", 32'd0, 32'd1);
        end
        adc_bus.new_sample     = 1'b1;
        adc_bus.sample         = 10'd800;
        adc_bus.sample_channel = 4'(CH);
        @(posedge clk);
        #1;
        adc_bus.new_sample = 1'b0;
        @(negedge clk);
        check("race_old", 32'(position), 32'd0);
        wait_frames(1);
        check("race_new", 32'(position), 32'd800);
`endif

        // Randomized traffic: mostly the selected channel, arbitrary timing.
        for (int i = 0; i < 150; i++) begin
            int ch;
            repeat ($urandom_range(0, 200)) @(posedge clk);
            ch = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : CH;
            send(ch, int'($urandom_range(0, 1023)));
        end
        wait_frames(2);

        // Reset mid-pulse discards the partial average.
        wait_frames(1);
        send(CH, 500); send(CH, 500);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("servo_mid_pulse", 32'(servo), 32'd1);
        pulse_reset();
        @(negedge clk);
        check("reset_position2", 32'(position), 32'd512);
        send4(CH, 10);
        wait_frames(1);
`ifndef ADC_SERVO_SLEW_LIMIT_EN
        check("avg_restart", 32'(position), 32'd10);
`endif
        wait_frames(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
